// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the seq_det_ctrl serial pattern engine.
// The optional SEQ_DET_FIRST_POS_EN build adds no package content.
package seq_det_pkg;

    localparam int SEQ_DEF_W     = 8;
    localparam int SEQ_DEF_PMAX  = 8;
    localparam int SEQ_DEF_CNT_W = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Low n bits set; callers keep only the width they need (n <= 32).
    function automatic logic [31:0] ones_mask(input int n);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_det_match.sv
// Mealy-style serial pattern matcher: bit history, seen counter, masked compare
// and the registered one-cycle match pulse.
module seq_det_match
    import seq_det_pkg::*;
#(
    parameter int PMAX = SEQ_DEF_PMAX,
    parameter int LW   = $clog2(SEQ_DEF_PMAX + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_shift,
    input  logic            i_bit,
    input  logic            i_flush,
    input  logic            i_clr,
    input  logic [PMAX-1:0] i_pat,
    input  logic [LW-1:0]   i_len,
    output logic            o_hit,
    output logic            o_pulse
);

    logic [PMAX-1:0] r_hist;
    logic [LW-1:0]   r_seen;
    logic            r_pulse;
    logic [31:0]     w_mask32;
    logic [PMAX-1:0] w_mask;
    logic [PMAX-1:0] w_new_hist;
    logic [LW-1:0]   w_seen_nxt;
    logic            w_cmp;

    assign w_mask32   = ones_mask(int'(i_len));
    assign w_mask     = w_mask32[PMAX-1:0];
    assign w_new_hist = {r_hist[PMAX-2:0], i_bit};
    assign w_seen_nxt = (r_seen >= LW'(PMAX)) ? r_seen : r_seen + 1'b1;
    assign w_cmp      = ((w_new_hist & w_mask) == (i_pat & w_mask)) && (w_seen_nxt >= i_len);

    // A clear on the same cycle swallows the match entirely.
    assign o_hit   = i_shift && w_cmp && !i_clr;
    assign o_pulse = r_pulse;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hist  <= '0;
            r_seen  <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= o_hit;
            if (i_clr || i_flush) begin
                r_hist <= '0;
                r_seen <= '0;
            end else if (i_shift) begin
                r_hist <= w_new_hist;
                r_seen <= w_seen_nxt;
            end
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Word-to-serial stream controller feeding seq_det_match; counts matches and
// raises a sticky threshold flag. `define SEQ_DET_FIRST_POS_EN adds first_pos/first_vld.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int W     = SEQ_DEF_W,
    parameter int PMAX  = SEQ_DEF_PMAX,
    parameter int CNT_W = SEQ_DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_load,
    input  logic [PMAX-1:0]           pat_in,
    input  logic [$clog2(PMAX+1)-1:0] pat_len,
    input  logic [CNT_W-1:0]          thresh,
    input  logic                      clr,
    input  logic                      in_valid,
    input  logic [W-1:0]              in_data,
    output logic                      in_ready,
    output logic                      busy,
    output logic                      match_pulse,
    output logic [CNT_W-1:0]          match_cnt,
    output logic                      thresh_hit
`ifdef SEQ_DET_FIRST_POS_EN
    ,
    output logic [31:0]               first_pos,
    output logic                      first_vld
`endif
);

    localparam int LW = $clog2(PMAX + 1);
    localparam int IW = (W > 1) ? $clog2(W) : 1;

    state_t           r_state, w_state_nxt;
    logic [W-1:0]     r_sreg;
    logic [IW-1:0]    r_idx;
    logic [PMAX-1:0]  r_pat;
    logic [LW-1:0]    r_len;
    logic [CNT_W-1:0] r_thresh;
    logic [CNT_W-1:0] r_cnt;
    logic             r_flag;
    logic             w_last, w_load, w_shift, w_cfg, w_hit;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_last = (r_idx == IW'(W - 1));
    assign w_load = in_valid && in_ready;
    assign w_cfg  = cfg_load && (r_state == ST_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Ready is also raised on the last bit so back-to-back words see no bubble.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        busy        = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                busy     = 1'b1;
                w_shift  = 1'b1;
                in_ready = w_last;
                if (w_last && !in_valid) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sreg <= '0;
            r_idx  <= '0;
        end else if (w_load) begin
            r_sreg <= in_data;
            r_idx  <= '0;
        end else if (w_shift) begin
            r_sreg <= {r_sreg[W-2:0], 1'b0};
            r_idx  <= r_idx + 1'b1;
        end
    end

    // A zero length behaves as a single-bit pattern; oversize lengths clamp.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pat    <= '0;
            r_len    <= LW'(1);
            r_thresh <= '0;
        end else if (w_cfg) begin
            r_pat    <= pat_in;
            r_len    <= (pat_len == '0) ? LW'(1) : (pat_len > LW'(PMAX)) ? LW'(PMAX) : pat_len;
            r_thresh <= thresh;
        end
    end

    seq_det_match #(.PMAX(PMAX), .LW(LW)) u_match (
        .clk     (clk),
        .reset   (reset),
        .i_shift (w_shift),
        .i_bit   (r_sreg[W-1]),
        .i_flush (w_cfg),
        .i_clr   (clr),
        .i_pat   (r_pat),
        .i_len   (r_len),
        .o_hit   (w_hit),
        .o_pulse (match_pulse)
    );

    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_flag <= 1'b0;
        end else if (clr) begin
            r_cnt  <= '0;
            r_flag <= 1'b0;
        end else if (w_hit) begin
            r_cnt <= w_cnt_inc;
            if ((r_thresh != '0) && (w_cnt_inc >= r_thresh)) r_flag <= 1'b1;
        end
    end

    assign match_cnt  = r_cnt;
    assign thresh_hit = r_flag;

`ifdef SEQ_DET_FIRST_POS_EN
    logic [31:0] r_gidx;
    logic [31:0] r_first_pos;
    logic        r_first_vld;

    // r_gidx is the index of the bit being shifted this cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gidx      <= '0;
            r_first_pos <= '0;
            r_first_vld <= 1'b0;
        end else if (clr) begin
            r_gidx      <= '0;
            r_first_pos <= '0;
            r_first_vld <= 1'b0;
        end else begin
            if (w_shift && !(&r_gidx)) r_gidx <= r_gidx + 1'b1;
            if (w_hit && !r_first_vld) begin
                r_first_pos <= r_gidx;
                r_first_vld <= 1'b1;
            end
        end
    end

    assign first_pos = r_first_pos;
    assign first_vld = r_first_vld;
`endif

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: a bit-level reference model fed from a
// scoreboard queue, a vector table, and hand-written corner sequences.
module tb_seq_det_ctrl;

    localparam int W     = 8;
    localparam int PMAX  = 8;
    localparam int CNT_W = 16;
    localparam int LW    = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             cfg_load = 1'b0;
    logic             clr = 1'b0;
    logic             in_valid = 1'b0;
    logic [PMAX-1:0]  pat_in = '0;
    logic [LW-1:0]    pat_len = '0;
    logic [CNT_W-1:0] thresh = '0;
    logic [W-1:0]     in_data = '0;

    logic             in_ready, busy, match_pulse, thresh_hit;
    logic [CNT_W-1:0] match_cnt;
    logic             s_in_ready, s_busy, s_pulse, s_hit;
    logic [1:0]       s_cnt;
`ifdef SEQ_DET_FIRST_POS_EN
    logic [31:0]      fp, s_fp;
    logic             fv, s_fv;
`endif

    int tests = 0;
    int fails = 0;
    int obs   = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    seq_det_ctrl #(.W(W), .PMAX(PMAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .pat_in(pat_in), .pat_len(pat_len),
        .thresh(thresh), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .busy(busy), .match_pulse(match_pulse),
        .match_cnt(match_cnt), .thresh_hit(thresh_hit)
`ifdef SEQ_DET_FIRST_POS_EN
        , .first_pos(fp), .first_vld(fv)
`endif
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    seq_det_ctrl #(.W(W), .PMAX(PMAX), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .pat_in(pat_in), .pat_len(pat_len),
        .thresh(thresh[1:0]), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .in_ready(s_in_ready), .busy(s_busy), .match_pulse(s_pulse),
        .match_cnt(s_cnt), .thresh_hit(s_hit)
`ifdef SEQ_DET_FIRST_POS_EN
        , .first_pos(s_fp), .first_vld(s_fv)
`endif
    );

    // ---------------- reference model ----------------
    logic            bitq[$];
    logic            m_state = 1'b0;
    int              m_idx = 0;
    logic [PMAX-1:0] m_hist = '0, m_pat = '0, m_nh;
    int              m_seen = 0, m_len = 1, m_thr = 0, m_cnt = 0, m_cnt2 = 0;
    logic            m_flag = 1'b0, m_pulse = 1'b0, m_b, m_hit;

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            bitq.delete();
            m_state = 1'b0; m_idx = 0; m_hist = '0; m_pat = '0; m_seen = 0; m_len = 1;
            m_thr = 0; m_cnt = 0; m_cnt2 = 0; m_flag = 1'b0; m_pulse = 1'b0;
        end else begin
            m_pulse = 1'b0;
            if (m_state) begin
                m_b = 1'b0;
                if (bitq.size() > 0) m_b = bitq.pop_front();
                m_nh  = {m_hist[PMAX-2:0], m_b};
                m_hit = (m_seen + 1 >= m_len);
                for (int i = 0; i < m_len; i++) if (m_nh[i] != m_pat[i]) m_hit = 1'b0;
                if (clr) begin
                    m_hist = '0; m_seen = 0; m_cnt = 0; m_cnt2 = 0; m_flag = 1'b0;
                end else begin
                    m_hist = m_nh;
                    if (m_seen < PMAX) m_seen++;
                    if (m_hit) begin
                        m_pulse = 1'b1;
                        if (m_cnt < 65535) m_cnt++;
                        if (m_cnt2 < 3) m_cnt2++;
                        if (m_thr != 0 && m_cnt >= m_thr) m_flag = 1'b1;
                    end
                end
                if (m_idx == W - 1) begin
                    if (in_valid) begin
                        for (int i = W - 1; i >= 0; i--) bitq.push_back(in_data[i]);
                        m_idx = 0;
                    end else begin
                        m_state = 1'b0;
                    end
                end else begin
                    m_idx++;
                end
            end else begin
                if (clr) begin
                    m_hist = '0; m_seen = 0; m_cnt = 0; m_cnt2 = 0; m_flag = 1'b0;
                end
                if (cfg_load) begin
                    m_pat = pat_in; m_len = (pat_len == 0) ? 1 : int'(pat_len); m_thr = int'(thresh);
                    m_hist = '0; m_seen = 0;
                end
                if (in_valid) begin
                    for (int i = W - 1; i >= 0; i--) bitq.push_back(in_data[i]);
                    m_state = 1'b1;
                    m_idx   = 0;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: check outputs against the model at negedge, then move to #1 past posedge.
    task automatic step();
        @(negedge clk);
        if (chk_en) begin
            chk("cyc_in_ready", in_ready, (!m_state || m_idx == W - 1));
            chk("cyc_busy", busy, m_state);
            chk("cyc_pulse", match_pulse, m_pulse);
            chk("cyc_cnt", match_cnt, m_cnt);
            chk("cyc_thresh_hit", thresh_hit, m_flag);
            chk("cyc_sat_cnt", s_cnt, m_cnt2);
        end
        if (match_pulse === 1'b1) obs++;
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic configure(input logic [7:0] p, input logic [3:0] l, input logic [15:0] t);
        cfg_load = 1'b1; clr = 1'b1; pat_in = p; pat_len = l; thresh = t;
        step();
        cfg_load = 1'b0; clr = 1'b0;
    endtask

    // Words are offered with in_valid held, so consecutive words go back-to-back.
    task automatic send_word(input logic [7:0] w, input bit last);
        int k;
        in_valid = 1'b1;
        in_data  = w;
        k = 0;
        while (in_ready !== 1'b1 && k < 50) begin
            step();
            k++;
        end
        if (k >= 50) chk("accept_timeout", 32'd0, 32'd1);
        step();
        if (last) in_valid = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  pat;
        logic [3:0]  len;
        logic [15:0] thr;
        int          nw;
        logic [7:0]  w0, w1, w2;
        int          e_pulses;
        int          e_cnt;
        logic        e_flag;
        int          e_cnt2;
    } vec_t;

    vec_t tbl[7];
    int   o0;

    initial begin
        tbl[0] = '{8'h1A, 4'd5, 16'd0, 1, 8'hDA, 8'h00, 8'h00, 1, 1, 1'b0, 1};
        tbl[1] = '{8'h1A, 4'd5, 16'd0, 2, 8'h1D, 8'h00, 8'h00, 1, 1, 1'b0, 1};
        tbl[2] = '{8'h03, 4'd2, 16'd7, 1, 8'hFF, 8'h00, 8'h00, 7, 7, 1'b1, 3};
        tbl[3] = '{8'h01, 4'd1, 16'd0, 1, 8'hA5, 8'h00, 8'h00, 4, 4, 1'b0, 3};
        tbl[4] = '{8'h00, 4'd0, 16'd2, 1, 8'hA5, 8'h00, 8'h00, 4, 4, 1'b1, 3};
        tbl[5] = '{8'hA5, 4'd8, 16'd2, 1, 8'hA5, 8'h00, 8'h00, 1, 1, 1'b0, 1};
        tbl[6] = '{8'h1A, 4'd5, 16'd3, 3, 8'hDA, 8'hDA, 8'hDA, 3, 3, 1'b1, 3};

        steps(3);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_pulse", match_pulse, 1'b0);
        chk("rst_cnt", match_cnt, 32'd0);
        chk("rst_thresh_hit", thresh_hit, 1'b0);
        reset  = 1'b1;
        chk_en = 1'b1;
        steps(2);

        for (int v = 0; v < 7; v++) begin
            configure(tbl[v].pat, tbl[v].len, tbl[v].thr);
            o0 = obs;
            send_word(tbl[v].w0, tbl[v].nw == 1);
            if (tbl[v].nw > 1) send_word(tbl[v].w1, tbl[v].nw == 2);
            if (tbl[v].nw > 2) send_word(tbl[v].w2, 1'b1);
            steps(W + 3);
            chk($sformatf("v%0d_pulses", v), obs - o0, tbl[v].e_pulses);
            chk($sformatf("v%0d_cnt", v), match_cnt, tbl[v].e_cnt);
            chk($sformatf("v%0d_flag", v), thresh_hit, tbl[v].e_flag);
            chk($sformatf("v%0d_sat_cnt", v), s_cnt, tbl[v].e_cnt2);
        end

        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_cnt", match_cnt, 32'd0);
        chk("clr_flag", thresh_hit, 1'b0);

        // cfg_load while serializing must not replace the 11010 pattern
        configure(8'h1A, 4'd5, 16'd0);
        o0 = obs;
        send_word(8'hDA, 1'b1);
        steps(2);
        cfg_load = 1'b1; pat_in = 8'h03; pat_len = 4'd2; thresh = 16'd1;
        step();
        cfg_load = 1'b0;
        steps(W + 3);
        chk("cfgbusy_pulses", obs - o0, 32'd1);
        chk("cfgbusy_cnt", match_cnt, 32'd1);
        chk("cfgbusy_flag", thresh_hit, 1'b0);

        // clr lands on the edge that shifts bit index 3 of 8'hFF (a match bit)
        configure(8'h03, 4'd2, 16'd0);
        o0 = obs;
        send_word(8'hFF, 1'b1);
        steps(3);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clrhit_pulse", match_pulse, 1'b0);
        chk("clrhit_cnt", match_cnt, 32'd0);
        chk("clrhit_sat_cnt", s_cnt, 32'd0);
        steps(W);
        chk("clrhit_pulses", obs - o0, 32'd5);
        chk("clrhit_cnt_end", match_cnt, 32'd3);

        // asynchronous reset at bit index 4 of a word that would match at index 7
        configure(8'h1A, 4'd5, 16'd0);
        o0 = obs;
        send_word(8'hDA, 1'b1);
        steps(4);
        reset = 1'b0;
        #1;
        chk("amid_in_ready", in_ready, 1'b1);
        chk("amid_busy", busy, 1'b0);
        chk("amid_pulse", match_pulse, 1'b0);
        chk("amid_cnt", match_cnt, 32'd0);
        chk("amid_sat_cnt", s_cnt, 32'd0);
        step();
        reset = 1'b1;
        steps(W + 4);
        chk("amid_pulses", obs - o0, 32'd0);
        chk("amid_cnt_end", match_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
- Stream controller and pattern engine for serial sequence detection. It accepts parallel words over a valid/ready handshake and serializes them MSB-first into a programmable Mealy-style pattern matcher, one bit per cycle.
- It counts pattern matches, including overlapping ones, and raises a sticky threshold flag.
- It sits between a word-wide producer and the serial detect logic. It replaces hand-driven single-bit stimulus with a scheduled bit stream.

Parameters:
- W, 8, data word width (bits serialized per word)
- PMAX, 8, maximum pattern length
- CNT_W, 16, match counter width

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- cfg_load  in  1  pulse: latch pat_in/pat_len/thresh (honoured in IDLE only)
- pat_in  in  PMAX  pattern, LSB = most recent bit; only low pat_len bits are used
- pat_len  in  $clog2(PMAX+1)  pattern length, legal 1..PMAX; 0 is treated as 1
- thresh  in  CNT_W  match-count threshold
- clr  in  1  synchronous clear of count, history, flag and bit-seen counter
- in_valid  in  1  word valid
- in_data  in  W  word, bit W-1 shifted first
- in_ready  out  1  word can be accepted
- busy  out  1  serializing in progress
- match_pulse  out  1  one-cycle pulse per match
- match_cnt  out  CNT_W  saturating match count
- thresh_hit  out  1  sticky: match_cnt >= thresh (with thresh != 0)

Behaviour:
- Reset (reset=0, asynchronous) forces the following:
  - state IDLE; in_ready=1; busy=0; match_pulse=0; match_cnt=0; thresh_hit=0.
  - history=0; seen counter=0; pattern=0; pat_len=1; thresh=0.
- State machine:
  - IDLE: in_ready=1. On in_valid&in_ready, load the shift register, set bit index=0 and go to SHIFT.
  - SHIFT: busy=1. Each cycle, shift the MSB into history and increment the index.
  - At index W-1, in_ready=1. If a word is accepted that cycle, reload the shift register, reset the index to 0 and stay in SHIFT (back-to-back, no bubble). Otherwise go to IDLE.
- Throughput: 1 bit/cycle; W cycles per word.
- Match evaluation on each shifted bit b:
  - new_hist = {hist[PMAX-2:0], b}.
  - Match iff (new_hist & mask) == (pattern & mask) AND seen+1 >= pat_len, where mask = low pat_len ones.
  - seen saturates at PMAX.
- Latency: match_pulse is registered and asserts the cycle after the edge that shifted the completing bit.
- History and seen persist across word boundaries and IDLE gaps. Matches spanning words are detected.
- Overlap: matches are evaluated on every bit with no history flush after a match.
- match_cnt increments on each match and saturates at 2^CNT_W-1. It never wraps.
- thresh_hit sets when the post-increment count >= thresh and thresh != 0. It stays set until clr or reset.
- cfg_load:
  - Accepted only in IDLE; ignored while busy.
  - Also clears history and seen. Does not clear match_cnt.
- clr:
  - Has priority over a same-cycle match: the count becomes 0 and no pulse is produced for that bit.
  - Does not abort serialization.
- Reset mid-word: the word in flight is discarded. No partial pulses are produced.

Optional Feature:
- SEQ_DET_FIRST_POS_EN
- Defined: adds output first_pos (32 bits) holding the global bit index of the first match since the last clr/reset, plus first_vld (1).
  - The global index counts shifted bits from clr/reset, starting at 0, and saturates.
  - first_vld=0 until a match occurs.
- Undefined: neither port nor the index counter exists.

Decomposition:
- Package seq_det_pkg holds:
  - FSM state typedef (IDLE, SHIFT).
  - Default W/PMAX/CNT_W constants.
  - A mask-generation function (ones of length n).
- One natural sub-module: seq_det_match, containing the history register, seen counter, masked compare and registered pulse.
- Top level keeps the FSM, serializer, counter and threshold logic.

Test Plan:
- Pattern 5'b11010, len 5; send 8'b11011010 -> exactly one match_pulse, one cycle after bit index 7 is shifted; match_cnt=1.
- Same pattern; send 8'b00011101 then 8'h00 back-to-back (in_valid held) -> in_ready high at index 7, no bubble; match on first bit of the second word; match_cnt=1.
- Pattern 2'b11, len 2; send 8'hFF -> 7 overlapping pulses on consecutive cycles; match_cnt=7.
- thresh=3, pattern 11010; feed 3 matching words -> thresh_hit sets with the third pulse. Assert clr -> match_cnt=0, thresh_hit=0.
- Pulse reset low mid-word (index 4) -> all outputs return to reset values immediately; no further pulses. cfg_load during SHIFT is ignored, verified by the old pattern still matching.
- CNT_W=2 build; force 5 matches -> match_cnt saturates at 3. Same-cycle clr and match -> count 0, no pulse.
